pwm_event_qualifier: RTL and testbench



---
 rtl/pwm_event_qualifier.sv | 173 +++++++++++++++++
 tb/tb_pwm_event_qualifier.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_event_qualifier.sv
// Qualifies PWM carrier peak/valley rises into single-cycle events with a
// programmable blanking window, plus event/period/rejection statistics.
module pwm_event_qualifier #(
  parameter int PERIOD_W = 32,
  parameter int CNT_W    = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic [1:0]          mode,
  input  logic [15:0]         min_gap,
  input  logic                clear,
  input  logic                pwm_carrier_low,
  input  logic                pwm_carrier_high,
  output logic                event_qualifier,
  output logic                event_src,
  output logic [CNT_W-1:0]    event_count,
  output logic [PERIOD_W-1:0] period,
  output logic                period_valid,
  output logic [15:0]         missed_count
);

  localparam logic [1:0] ST_DISABLED = 2'd0;
  localparam logic [1:0] ST_ARMED    = 2'd1;
  localparam logic [1:0] ST_BLANK    = 2'd2;

  localparam logic [PERIOD_W-1:0] PERIOD_ONE = {{(PERIOD_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]    CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

  function automatic logic [PERIOD_W-1:0] sat_inc_period(input logic [PERIOD_W-1:0] v);
    return (&v) ? v : v + PERIOD_ONE;
  endfunction

  function automatic logic [15:0] sat_inc_16(input logic [15:0] v);
    return (&v) ? v : v + 16'd1;
  endfunction

  logic [1:0]          state_q, state_d;
  logic                low_q, high_q;
  logic [15:0]         blank_cnt_q, blank_cnt_d;
  logic [PERIOD_W-1:0] period_cnt_q, period_cnt_d;
  logic                ref_valid_q, ref_valid_d;
  logic                pulse_q, pulse_d;
  logic                src_q, src_d;
  logic [CNT_W-1:0]    event_count_q, event_count_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic                period_valid_q, period_valid_d;
  logic [15:0]         missed_q, missed_d;

  logic active;
  logic rise_low, rise_high;
  logic qual, qual_src;
  logic gap_ok;
  logic blank_needed;
  logic accept, reject;

  // Edge detection and acceptance decision, all within the detection cycle.
  always_comb begin
    active       = enable && (mode != 2'b00);
    rise_low     = pwm_carrier_low  & ~low_q;
    rise_high    = pwm_carrier_high & ~high_q;
    qual         = (mode[0] & rise_low) | (mode[1] & rise_high);
    // Peak wins when both sources rise together.
    qual_src     = mode[1] & rise_high;
    gap_ok       = (blank_cnt_q >= min_gap);
    blank_needed = (min_gap > 16'd1);
    accept       = active && qual &&
                   ((state_q == ST_ARMED) || ((state_q == ST_BLANK) && gap_ok));
    reject       = active && qual && (state_q == ST_BLANK) && !gap_ok;
  end

  always_comb begin
    state_d = state_q;
    if (!active) begin
      state_d = ST_DISABLED;
    end else begin
      case (state_q)
        ST_DISABLED: state_d = ST_ARMED;
        ST_ARMED:    state_d = (accept && blank_needed) ? ST_BLANK : ST_ARMED;
        ST_BLANK: begin
          if (accept)      state_d = blank_needed ? ST_BLANK : ST_ARMED;
          else if (gap_ok) state_d = ST_ARMED;
          else             state_d = ST_BLANK;
        end
        default:     state_d = ST_DISABLED;
      endcase
    end
  end

  // Both counters read T-T0 in the cycle T after an accept at T0.
  always_comb begin
    blank_cnt_d  = blank_cnt_q;
    period_cnt_d = period_cnt_q;
    ref_valid_d  = ref_valid_q;
    if (!active) begin
      blank_cnt_d  = 16'd0;
      period_cnt_d = '0;
      ref_valid_d  = 1'b0;
    end else if (accept) begin
      blank_cnt_d  = 16'd1;
      period_cnt_d = PERIOD_ONE;
      ref_valid_d  = 1'b1;
    end else begin
      blank_cnt_d  = sat_inc_16(blank_cnt_q);
      period_cnt_d = sat_inc_period(period_cnt_q);
      if (clear) ref_valid_d = 1'b0;
    end
  end

  always_comb begin
    pulse_d        = accept;
    src_d          = accept ? qual_src : src_q;
    event_count_d  = event_count_q;
    period_d       = period_q;
    period_valid_d = period_valid_q;
    missed_d       = missed_q;

    if (clear)       event_count_d = accept ? CNT_ONE : '0;
    else if (accept) event_count_d = event_count_q + CNT_ONE;

    // An accept coincident with clear only becomes the new reference.
    if (clear) begin
      period_d       = '0;
      period_valid_d = 1'b0;
    end else if (!active) begin
      period_valid_d = 1'b0;
    end else if (accept && ref_valid_q) begin
      period_d       = period_cnt_q;
      period_valid_d = 1'b1;
    end

    if (clear)       missed_d = 16'd0;
    else if (reject) missed_d = sat_inc_16(missed_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_DISABLED;
      low_q          <= 1'b0;
      high_q         <= 1'b0;
      blank_cnt_q    <= 16'd0;
      period_cnt_q   <= '0;
      ref_valid_q    <= 1'b0;
      pulse_q        <= 1'b0;
      src_q          <= 1'b0;
      event_count_q  <= '0;
      period_q       <= '0;
      period_valid_q <= 1'b0;
      missed_q       <= 16'd0;
    end else begin
      state_q        <= state_d;
      low_q          <= pwm_carrier_low;
      high_q         <= pwm_carrier_high;
      blank_cnt_q    <= blank_cnt_d;
      period_cnt_q   <= period_cnt_d;
      ref_valid_q    <= ref_valid_d;
      pulse_q        <= pulse_d;
      src_q          <= src_d;
      event_count_q  <= event_count_d;
      period_q       <= period_d;
      period_valid_q <= period_valid_d;
      missed_q       <= missed_d;
    end
  end

  assign event_qualifier = pulse_q;
  assign event_src       = src_q;
  assign event_count     = event_count_q;
  assign period          = period_q;
  assign period_valid    = period_valid_q;
  assign missed_count    = missed_q;

endmodule

// File: tb/tb_pwm_event_qualifier.sv
// Scoreboard bench for pwm_event_qualifier: directed carrier edges push the
// expected event record; a negedge monitor pops it on each qualified pulse.
module tb_pwm_event_qualifier;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic [15:0] min_gap = 16'd0;
  logic        clear = 1'b0;
  logic        pwm_carrier_low = 1'b0;
  logic        pwm_carrier_high = 1'b0;
  logic        event_qualifier;
  logic        event_src;
  logic [31:0] event_count;
  logic [31:0] period;
  logic        period_valid;
  logic [15:0] missed_count;

  int nvec = 0;
  int nmis = 0;

  typedef struct {
    logic        src;
    logic [31:0] cnt;
    logic [31:0] per;
    logic        pv;
    logic [15:0] miss;
  } exp_t;

  exp_t sb[$];

  pwm_event_qualifier #(.PERIOD_W(32), .CNT_W(32)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .enable           (enable),
    .mode             (mode),
    .min_gap          (min_gap),
    .clear            (clear),
    .pwm_carrier_low  (pwm_carrier_low),
    .pwm_carrier_high (pwm_carrier_high),
    .event_qualifier  (event_qualifier),
    .event_src        (event_src),
    .event_count      (event_count),
    .period           (period),
    .period_valid     (period_valid),
    .missed_count     (missed_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got %0d required %0d", name, got, exp);
    end
  endtask

  // Monitor: every pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && event_qualifier) begin
      if (sb.size() == 0) begin
        nvec++;
        nmis++;
        $display("FAIL unexpected_pulse: got pulse with count %0d required no pulse", event_count);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("event_src",    {31'd0, event_src},    {31'd0, e.src});
        check("event_count",  event_count,           e.cnt);
        check("period",       period,                e.per);
        check("period_valid", {31'd0, period_valid}, {31'd0, e.pv});
        check("missed_count", {16'd0, missed_count}, {16'd0, e.miss});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic expect_evt(input logic src, input logic [31:0] cnt, input logic [31:0] per,
                            input logic pv, input logic [15:0] miss);
    exp_t e;
    e.src = src; e.cnt = cnt; e.per = per; e.pv = pv; e.miss = miss;
    sb.push_back(e);
  endtask

  // Each rise occupies one cycle; spacing between rises is 1 + idle count.
  task automatic rise(input logic hi, input logic lo);
    pwm_carrier_high = hi;
    pwm_carrier_low  = lo;
    tick();
    pwm_carrier_high = 1'b0;
    pwm_carrier_low  = 1'b0;
  endtask

  initial begin
    tick();
    check("reset_count",  event_count, 32'd0);
    check("reset_period", period, 32'd0);
    check("reset_pulse",  {31'd0, event_qualifier}, 32'd0);
    rst_n = 1'b1;
    idle(2);

    // Peak events every 100 clocks.
    enable = 1'b1; mode = 2'b10; min_gap = 16'd0;
    idle(3);
    for (int k = 1; k <= 4; k++) begin
      expect_evt(1'b1, k, (k == 1) ? 32'd0 : 32'd100, k > 1, 16'd0);
      rise(1'b1, 1'b0);
      idle(99);
    end

    // Simultaneous rises give one peak event; valley 50 clocks later.
    mode = 2'b11;
    expect_evt(1'b1, 32'd5, 32'd100, 1'b1, 16'd0);
    rise(1'b1, 1'b1);
    idle(49);
    expect_evt(1'b0, 32'd6, 32'd50, 1'b1, 16'd0);
    rise(1'b0, 1'b1);
    idle(10);

    // Valley with 60-clock blanking; a rejected edge does not restart the window.
    enable = 1'b0;
    idle(3);
    check("pv_after_disable", {31'd0, period_valid}, 32'd0);
    mode = 2'b01; min_gap = 16'd60; enable = 1'b1;
    idle(3);
    expect_evt(1'b0, 32'd7, 32'd50, 1'b0, 16'd0);
    rise(1'b0, 1'b1);
    idle(39);
    rise(1'b0, 1'b1);
    idle(19);
    expect_evt(1'b0, 32'd8, 32'd60, 1'b1, 16'd1);
    rise(1'b0, 1'b1);
    idle(29);
    rise(1'b0, 1'b1);
    idle(29);
    expect_evt(1'b0, 32'd9, 32'd60, 1'b1, 16'd2);
    rise(1'b0, 1'b1);
    idle(5);

    // Enabling with carrier already high yields nothing until a fresh rise.
    enable = 1'b0; mode = 2'b10; min_gap = 16'd0;
    pwm_carrier_high = 1'b1;
    idle(3);
    enable = 1'b1;
    idle(5);
    pwm_carrier_high = 1'b0;
    idle(2);
    expect_evt(1'b1, 32'd10, 32'd60, 1'b0, 16'd2);
    rise(1'b1, 1'b0);
    idle(19);
    expect_evt(1'b1, 32'd11, 32'd20, 1'b1, 16'd2);
    rise(1'b1, 1'b0);
    idle(10);
    // Enable drops in the rise cycle: edge discarded.
    enable = 1'b0;
    rise(1'b1, 1'b0);
    idle(3);
    check("drop_pv",    {31'd0, period_valid}, 32'd0);
    check("drop_count", event_count, 32'd11);
    check("drop_period", period, 32'd20);

    // Five events, then clear coincident with an accepted edge.
    enable = 1'b1;
    idle(3);
    expect_evt(1'b1, 32'd12, 32'd20, 1'b0, 16'd2);
    rise(1'b1, 1'b0);
    for (int k = 13; k <= 16; k++) begin
      idle(9);
      expect_evt(1'b1, k, 32'd10, 1'b1, 16'd2);
      rise(1'b1, 1'b0);
    end
    idle(9);
    expect_evt(1'b1, 32'd1, 32'd0, 1'b0, 16'd0);
    clear = 1'b1;
    rise(1'b1, 1'b0);
    clear = 1'b0;
    idle(199);
    expect_evt(1'b1, 32'd2, 32'd200, 1'b1, 16'd0);
    rise(1'b1, 1'b0);

    // Enter a long blank window, record a miss, then reset asynchronously.
    min_gap = 16'd1000;
    idle(9);
    expect_evt(1'b1, 32'd3, 32'd10, 1'b1, 16'd0);
    rise(1'b1, 1'b0);
    idle(19);
    rise(1'b1, 1'b0);
    idle(3);
    check("pre_reset_missed", {16'd0, missed_count}, 32'd1);
    check("pre_reset_count", event_count, 32'd3);
    pwm_carrier_high = 1'b1;
    idle(2);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_count",  event_count, 32'd0);
    check("async_missed", {16'd0, missed_count}, 32'd0);
    check("async_period", period, 32'd0);
    check("async_pv",     {31'd0, period_valid}, 32'd0);
    check("async_src",    {31'd0, event_src}, 32'd0);
    tick();
    rst_n = 1'b1;
    idle(6);
    pwm_carrier_high = 1'b0;
    idle(2);
    expect_evt(1'b1, 32'd1, 32'd0, 1'b0, 16'd0);
    rise(1'b1, 1'b0);
    idle(5);

    check("outstanding_expectations", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
